// File: rtl/recon_check.sv
// recon_check: captures the network input X and the nine sigmoid outputs
// Y_0..Y_8 on a start pulse. It then scans them one per clock and produces:
//   - a thresholded reconstruction,
//   - the Hamming error against X,
//   - the argmax index and value.
// The result is returned through a valid/ready handshake.
//
// Optional feature: define RECON_ABS_ERR_EN to accumulate sum |Y_i - target_i|
// into err_sum. Without it, err_sum is tied to zero.
//
// Handshake: out_valid is high for the whole DONE state. All result outputs
// hold stable while out_valid=1 && out_ready=0. The result is consumed on the
// rising edge where out_valid && out_ready.

module recon_check #(
    parameter logic signed [19:0] THRESH = 20'sh08000
`ifdef RECON_ABS_ERR_EN
  , parameter logic signed [19:0] ONE_VAL = 20'sh10000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  X,
    input  logic [19:0] Y_0,
    input  logic [19:0] Y_1,
    input  logic [19:0] Y_2,
    input  logic [19:0] Y_3,
    input  logic [19:0] Y_4,
    input  logic [19:0] Y_5,
    input  logic [19:0] Y_6,
    input  logic [19:0] Y_7,
    input  logic [19:0] Y_8,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  recon,
    output logic [3:0]  err_cnt,
    output logic [3:0]  max_idx,
    output logic [19:0] max_val,
    output logic [23:0] err_sum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [8:0]       xcap_q, xcap_d;
    logic [8:0][19:0] ycap_q, ycap_d;

    // Working accumulators, valid only while scanning.
    logic [8:0]       wrec_q, wrec_d;
    logic [3:0]       werr_q, werr_d;
    logic [3:0]       wmidx_q, wmidx_d;
    logic [19:0]      wmval_q, wmval_d;

    // Output registers, loaded only on the SCAN->DONE edge.
    logic [8:0]       recon_q, recon_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic [3:0]       max_idx_q, max_idx_d;
    logic [19:0]      max_val_q, max_val_d;

    // Per-element terms for the element currently addressed by idx_q.
    logic [19:0]      y_cur;
    logic [3:0]       pos;
    logic             x_bit;
    logic             y_bit;
    logic             new_max;

`ifdef RECON_ABS_ERR_EN
    logic [23:0]        wsum_q, wsum_d;
    logic [23:0]        sum_q, sum_d;
    logic signed [20:0] diff;
    logic [20:0]        diff_abs;
`endif

    // Select the current element, then derive its threshold bit, its X pair
    // and whether it becomes the new maximum.
    always_comb begin
        y_cur = '0;
        case (idx_q)
            4'd0:    y_cur = ycap_q[0];
            4'd1:    y_cur = ycap_q[1];
            4'd2:    y_cur = ycap_q[2];
            4'd3:    y_cur = ycap_q[3];
            4'd4:    y_cur = ycap_q[4];
            4'd5:    y_cur = ycap_q[5];
            4'd6:    y_cur = ycap_q[6];
            4'd7:    y_cur = ycap_q[7];
            4'd8:    y_cur = ycap_q[8];
            default: y_cur = '0;
        endcase
        // Y_i pairs with X[8-i]; recon uses the same bit ordering.
        pos     = 4'd8 - idx_q;
        x_bit   = xcap_q[pos];
        y_bit   = ($signed(y_cur) >= THRESH);
        // Strict compare keeps the lowest index on ties.
        new_max = (idx_q == 4'd0) || ($signed(y_cur) > $signed(wmval_q));
    end

`ifdef RECON_ABS_ERR_EN
    // Absolute error against the 0/ONE_VAL target.
    // 21 bits so the subtraction cannot wrap.
    always_comb begin
        diff     = $signed({y_cur[19], y_cur})
                 - (x_bit ? $signed({ONE_VAL[19], ONE_VAL}) : 21'sd0);
        diff_abs = diff[20] ? $unsigned(-diff) : $unsigned(diff);
    end
`endif

    // Next-state and datapath updates for capture, scan and result hand-off.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xcap_d    = xcap_q;
        ycap_d    = ycap_q;
        wrec_d    = wrec_q;
        werr_d    = werr_q;
        wmidx_d   = wmidx_q;
        wmval_d   = wmval_q;
        recon_d   = recon_q;
        err_cnt_d = err_cnt_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
`ifdef RECON_ABS_ERR_EN
        wsum_d    = wsum_q;
        sum_d     = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xcap_d  = X;
                    ycap_d  = {Y_8, Y_7, Y_6, Y_5, Y_4, Y_3, Y_2, Y_1, Y_0};
                    wrec_d  = '0;
                    werr_d  = '0;
                    wmidx_d = '0;
                    wmval_d = '0;
`ifdef RECON_ABS_ERR_EN
                    wsum_d  = '0;
`endif
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                wrec_d[pos] = y_bit;
                werr_d      = werr_q + {3'b000, y_bit ^ x_bit};
                if (new_max) begin
                    wmidx_d = idx_q;
                    wmval_d = y_cur;
                end
`ifdef RECON_ABS_ERR_EN
                wsum_d = wsum_q + {3'b000, diff_abs};
`endif
                idx_d = idx_q + 4'd1;
                // The last element is folded in on the same edge that publishes the result.
                if (idx_q == 4'd8) begin
                    recon_d   = wrec_d;
                    err_cnt_d = werr_d;
                    max_idx_d = wmidx_d;
                    max_val_d = wmval_d;
`ifdef RECON_ABS_ERR_EN
                    sum_d     = wsum_d;
`endif
                    idx_d     = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // A start on this edge is ignored because the FSM is not yet in IDLE.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            xcap_q    <= '0;
            ycap_q    <= '0;
            wrec_q    <= '0;
            werr_q    <= '0;
            wmidx_q   <= '0;
            wmval_q   <= '0;
            recon_q   <= '0;
            err_cnt_q <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xcap_q    <= xcap_d;
            ycap_q    <= ycap_d;
            wrec_q    <= wrec_d;
            werr_q    <= werr_d;
            wmidx_q   <= wmidx_d;
            wmval_q   <= wmval_d;
            recon_q   <= recon_d;
            err_cnt_q <= err_cnt_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
        end
    end

`ifdef RECON_ABS_ERR_EN
    // Absolute-error accumulator and its published copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsum_q <= '0;
            sum_q  <= '0;
        end else begin
            wsum_q <= wsum_d;
            sum_q  <= sum_d;
        end
    end
    assign err_sum = sum_q;
`else
    assign err_sum = '0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign recon     = recon_q;
    assign err_cnt   = err_cnt_q;
    assign max_idx   = max_idx_q;
    assign max_val   = max_val_q;

endmodule
